// File: rtl/l2_arb_pkg.sv
// Shared types and default widths for the dual-L1 L2 port arbiter.
package l2_arb_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_LINE_W = 128;
   localparam int OFFSET_W   = 4;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      RD_REQ,
      RD_WAIT,
      RESP
   } l2arb_state_t;

   typedef enum logic {
      PORT_A,
      PORT_B
   } l2arb_port_t;

endpackage

// File: rtl/l2_arb_port_slot.sv
// Per-L1 request capture: one read slot and one evict slot, each holding a
// single outstanding pulse, plus sticky overflow detection.
module l2_arb_port_slot
   import l2_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LINE_W = DEF_LINE_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic              read_valid,
   input  logic              evict_wren,
   input  logic [LINE_W-1:0] evict_line,
   input  logic              clr_read,
   input  logic              clr_evict,
   output logic              rd_pend,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              ev_pend,
   output logic [ADDR_W-1:0] ev_addr,
   output logic [LINE_W-1:0] ev_line,
   output logic              overflow
);

   localparam int TAG_W = ADDR_W - OFFSET_W;

   logic [TAG_W-1:0] rd_tag;
   logic [TAG_W-1:0] ev_tag;
   logic             rd_free;
   logic             ev_free;
   logic             unused_offset;

   // A slot being cleared this cycle can take a new pulse at the same edge.
   assign rd_free = !rd_pend || clr_read;
   assign ev_free = !ev_pend || clr_evict;

   assign rd_addr       = {rd_tag, {OFFSET_W{1'b0}}};
   assign ev_addr       = {ev_tag, {OFFSET_W{1'b0}}};
   assign unused_offset = ^addr[OFFSET_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend  <= 1'b0;
         rd_tag   <= '0;
         ev_pend  <= 1'b0;
         ev_tag   <= '0;
         ev_line  <= '0;
         overflow <= 1'b0;
      end else begin
         if (read_valid && rd_free) begin
            rd_pend <= 1'b1;
            rd_tag  <= addr[ADDR_W-1:OFFSET_W];
         end else if (clr_read) begin
            rd_pend <= 1'b0;
         end

         if (evict_wren && ev_free) begin
            ev_pend <= 1'b1;
            ev_tag  <= addr[ADDR_W-1:OFFSET_W];
            ev_line <= evict_line;
         end else if (clr_evict) begin
            ev_pend <= 1'b0;
         end

         if ((read_valid && !rd_free) || (evict_wren && !ev_free))
            overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/l2_port_arbiter.sv
// Serialises L1a/L1b line fills and evictions onto one L2 port, evictions
// first. Build option L2ARB_ROUND_ROBIN_EN: alternating contended read grant.
module l2_port_arbiter
   import l2_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LINE_W = DEF_LINE_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic              a_read_valid,
   input  logic              a_evict_wren,
   input  logic [LINE_W-1:0] a_evict_line,
   input  logic              a_irq,
   output logic [LINE_W-1:0] a_update_line,
   output logic              a_update_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic              b_read_valid,
   input  logic              b_evict_wren,
   input  logic [LINE_W-1:0] b_evict_line,
   input  logic              b_irq,
   output logic [LINE_W-1:0] b_update_line,
   output logic              b_update_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rden,
   output logic              mem_wren,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_rdata_valid,
   output logic              overflow_err
);

   l2arb_state_t state;
   l2arb_port_t  grant;

   logic              a_rd_pend, a_ev_pend, a_ovf;
   logic              b_rd_pend, b_ev_pend, b_ovf;
   logic [ADDR_W-1:0] a_rd_addr, a_ev_addr;
   logic [ADDR_W-1:0] b_rd_addr, b_ev_addr;
   logic [LINE_W-1:0] a_ev_line, b_ev_line;
   logic              a_clr_rd, a_clr_ev, b_clr_rd, b_clr_ev;
   logic              wr_done, resp_fire, grant_irq;
   logic              a_rd_ok, b_rd_ok, rd_any, rd_pick_b;
`ifdef L2ARB_ROUND_ROBIN_EN
   logic              rr_favour_b;
`endif

   l2_arb_port_slot #(
      .ADDR_W (ADDR_W),
      .LINE_W (LINE_W)
   ) u_slot_a (
      .clk        (clk),
      .reset      (reset),
      .addr       (a_addr),
      .read_valid (a_read_valid),
      .evict_wren (a_evict_wren),
      .evict_line (a_evict_line),
      .clr_read   (a_clr_rd),
      .clr_evict  (a_clr_ev),
      .rd_pend    (a_rd_pend),
      .rd_addr    (a_rd_addr),
      .ev_pend    (a_ev_pend),
      .ev_addr    (a_ev_addr),
      .ev_line    (a_ev_line),
      .overflow   (a_ovf)
   );

   l2_arb_port_slot #(
      .ADDR_W (ADDR_W),
      .LINE_W (LINE_W)
   ) u_slot_b (
      .clk        (clk),
      .reset      (reset),
      .addr       (b_addr),
      .read_valid (b_read_valid),
      .evict_wren (b_evict_wren),
      .evict_line (b_evict_line),
      .clr_read   (b_clr_rd),
      .clr_evict  (b_clr_ev),
      .rd_pend    (b_rd_pend),
      .rd_addr    (b_rd_addr),
      .ev_pend    (b_ev_pend),
      .ev_addr    (b_ev_addr),
      .ev_line    (b_ev_line),
      .overflow   (b_ovf)
   );

   assign grant_irq = (grant == PORT_A) ? a_irq : b_irq;
   assign wr_done   = (state == WR_REQ) && mem_ready;
   assign resp_fire = (state == RESP) && !grant_irq;

   assign a_clr_ev = wr_done && (grant == PORT_A);
   assign b_clr_ev = wr_done && (grant == PORT_B);
   assign a_clr_rd = resp_fire && (grant == PORT_A);
   assign b_clr_rd = resp_fire && (grant == PORT_B);

   // Fill pulse follows the live irq so it fires the first cycle irq drops.
   assign a_update_valid = (state == RESP) && (grant == PORT_A) && !a_irq;
   assign b_update_valid = (state == RESP) && (grant == PORT_B) && !b_irq;
   assign overflow_err   = a_ovf || b_ovf;

   // A read must not overtake a pending eviction of the same line.
   assign a_rd_ok = a_rd_pend
                    && !(a_ev_pend && (a_ev_addr == a_rd_addr))
                    && !(b_ev_pend && (b_ev_addr == a_rd_addr));
   assign b_rd_ok = b_rd_pend
                    && !(a_ev_pend && (a_ev_addr == b_rd_addr))
                    && !(b_ev_pend && (b_ev_addr == b_rd_addr));
   assign rd_any  = a_rd_ok || b_rd_ok;

`ifdef L2ARB_ROUND_ROBIN_EN
   assign rd_pick_b = b_rd_ok && (!a_rd_ok || rr_favour_b);
`else
   assign rd_pick_b = b_rd_ok && !a_rd_ok;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         grant         <= PORT_A;
         mem_addr      <= '0;
         mem_rden      <= 1'b0;
         mem_wren      <= 1'b0;
         mem_wdata     <= '0;
         a_update_line <= '0;
         b_update_line <= '0;
`ifdef L2ARB_ROUND_ROBIN_EN
         rr_favour_b   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (a_ev_pend) begin
                  grant     <= PORT_A;
                  mem_addr  <= a_ev_addr;
                  mem_wdata <= a_ev_line;
                  mem_wren  <= 1'b1;
                  state     <= WR_REQ;
               end else if (b_ev_pend) begin
                  grant     <= PORT_B;
                  mem_addr  <= b_ev_addr;
                  mem_wdata <= b_ev_line;
                  mem_wren  <= 1'b1;
                  state     <= WR_REQ;
               end else if (rd_any) begin
                  grant    <= rd_pick_b ? PORT_B : PORT_A;
                  mem_addr <= rd_pick_b ? b_rd_addr : a_rd_addr;
                  mem_rden <= 1'b1;
                  state    <= RD_REQ;
`ifdef L2ARB_ROUND_ROBIN_EN
                  // Pointer moves only on contended grants.
                  if (a_rd_ok && b_rd_ok)
                     rr_favour_b <= !rd_pick_b;
`endif
               end
            end
            WR_REQ: begin
               if (mem_ready) begin
                  mem_wren <= 1'b0;
                  state    <= IDLE;
               end
            end
            RD_REQ: begin
               if (mem_ready) begin
                  mem_rden <= 1'b0;
                  state    <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (mem_rdata_valid) begin
                  if (grant == PORT_A)
                     a_update_line <= mem_rdata;
                  else
                     b_update_line <= mem_rdata;
                  state <= RESP;
               end
            end
            RESP: begin
               if (!grant_irq)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboard bench for l2_port_arbiter: directed requests against a simple
// one-cycle-latency memory; a negedge monitor checks every memory accept and fill.
module tb_l2_port_arbiter;

   localparam int AW = 32;
   localparam int LW = 128;
   localparam int K_RD  = 0;
   localparam int K_WR  = 1;
   localparam int K_UPD = 2;

   localparam logic [LW-1:0] D1 = 128'hDEAD0000_11112222_33334444_5555BEEF;
   localparam logic [LW-1:0] D2 = 128'h12401240_AAAA5555_0F0F0F0F_C3C3C3C3;
   localparam logic [LW-1:0] D3 = 128'h20002000_01020304_05060708_090A0B0C;
   localparam logic [LW-1:0] D4 = 128'h30003000_F0E0D0C0_B0A09080_70605040;
   localparam logic [LW-1:0] D5 = 128'h40004000_CAFEF00D_8BADF00D_FEEDFACE;
   localparam logic [LW-1:0] D6 = 128'h50005000_13579BDF_2468ACE0_55AA55AA;
   localparam logic [LW-1:0] D7 = 128'h60006000_00000001_00000002_00000003;

   logic          clk;
   logic          reset;
   logic [AW-1:0] a_addr, b_addr;
   logic          a_read_valid, b_read_valid;
   logic          a_evict_wren, b_evict_wren;
   logic [LW-1:0] a_evict_line, b_evict_line;
   logic          a_irq, b_irq;
   logic [LW-1:0] a_update_line, b_update_line;
   logic          a_update_valid, b_update_valid;
   logic [AW-1:0] mem_addr;
   logic          mem_rden, mem_wren;
   logic [LW-1:0] mem_wdata;
   logic          mem_ready;
   logic [LW-1:0] mem_rdata;
   logic          mem_rdata_valid;
   logic          overflow_err;

   typedef struct {
      int            kind;
      logic          port;
      logic [AW-1:0] addr;
      logic [LW-1:0] data;
   } exp_t;

   exp_t          q[$];
   int            total = 0;
   int            bad   = 0;
   logic [LW-1:0] mem_store [logic [AW-1:0]];
   logic          hold_rd;

   l2_port_arbiter #(
      .ADDR_W (AW),
      .LINE_W (LW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .a_addr          (a_addr),
      .a_read_valid    (a_read_valid),
      .a_evict_wren    (a_evict_wren),
      .a_evict_line    (a_evict_line),
      .a_irq           (a_irq),
      .a_update_line   (a_update_line),
      .a_update_valid  (a_update_valid),
      .b_addr          (b_addr),
      .b_read_valid    (b_read_valid),
      .b_evict_wren    (b_evict_wren),
      .b_evict_line    (b_evict_line),
      .b_irq           (b_irq),
      .b_update_line   (b_update_line),
      .b_update_valid  (b_update_valid),
      .mem_addr        (mem_addr),
      .mem_rden        (mem_rden),
      .mem_wren        (mem_wren),
      .mem_wdata       (mem_wdata),
      .mem_ready       (mem_ready),
      .mem_rdata       (mem_rdata),
      .mem_rdata_valid (mem_rdata_valid),
      .overflow_err    (overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input int kind, input logic port, input logic [AW-1:0] addr,
                       input logic [LW-1:0] data);
      exp_t e;
      e.kind = kind;
      e.port = port;
      e.addr = addr;
      e.data = data;
      q.push_back(e);
   endtask

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic observe(input int kind, input logic port, input logic [AW-1:0] addr,
                          input logic [LW-1:0] data);
      exp_t e;
      total++;
      if (q.size() == 0) begin
         bad++;
         $display("FAIL sb_unexpected actual kind=%0d port=%0d addr=%h data=%h required=nothing",
                  kind, port, addr, data);
      end else begin
         e = q.pop_front();
         if (e.kind != kind
             || (kind == K_UPD && e.port !== port)
             || (kind != K_UPD && e.addr !== addr)
             || (kind != K_RD  && e.data !== data)) begin
            bad++;
            $display("FAIL sb_event actual kind=%0d port=%0d addr=%h data=%h required kind=%0d port=%0d addr=%h data=%h",
                     kind, port, addr, data, e.kind, e.port, e.addr, e.data);
         end
      end
   endtask

   // Monitor: every accepted request and every fill pulse must match the queue head.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (mem_rden && mem_ready) observe(K_RD, 1'b0, mem_addr, '0);
            if (mem_wren && mem_ready) observe(K_WR, 1'b0, mem_addr, mem_wdata);
            if (a_update_valid)        observe(K_UPD, 1'b0, '0, a_update_line);
            if (b_update_valid)        observe(K_UPD, 1'b1, '0, b_update_line);
         end
      end
   end

   // Memory model: r=1 read latency unless hold_rd stretches it.
   initial begin
      logic [AW-1:0] raddr;
      mem_rdata_valid = 1'b0;
      mem_rdata       = '0;
      forever begin
         @(negedge clk);
         if (mem_wren && mem_ready) mem_store[mem_addr] = mem_wdata;
         if (mem_rden && mem_ready) begin
            raddr = mem_addr;
            @(posedge clk); #1;
            while (hold_rd) begin
               @(posedge clk); #1;
            end
            mem_rdata       = mem_store.exists(raddr) ? mem_store[raddr] : '0;
            mem_rdata_valid = 1'b1;
            @(posedge clk); #1;
            mem_rdata_valid = 1'b0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   function automatic logic outs_nonzero();
      return |{mem_addr, mem_rden, mem_wren, mem_wdata, a_update_line, b_update_line,
               a_update_valid, b_update_valid, overflow_err};
   endfunction

   task automatic wait_drain(input string name);
      int n = 0;
      while (q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL %s_drain actual=%0d_pending required=0", name, q.size());
         q.delete();
      end
      repeat (3) tick();
   endtask

   initial begin
      reset = 1'b1;
      a_addr = '0; b_addr = '0;
      a_read_valid = 1'b0; b_read_valid = 1'b0;
      a_evict_wren = 1'b0; b_evict_wren = 1'b0;
      a_evict_line = '0; b_evict_line = '0;
      a_irq = 1'b0; b_irq = 1'b0;
      mem_ready = 1'b1;
      hold_rd = 1'b0;
      mem_store[32'h0000_1230] = D1;
      mem_store[32'h0000_1240] = D2;
      mem_store[32'h0000_2000] = D3;
      mem_store[32'h0000_3000] = D4;
      mem_store[32'h0000_5000] = D6;
      mem_store[32'h0000_6000] = D7;

      repeat (3) tick();
      samp();
      check("reset_outputs", outs_nonzero(), 0);
      tick();
      reset = 1'b0;
      tick();

      // Minimum-latency read; offset bits of the address must be dropped.
      a_addr = 32'h0000_1237;
      a_read_valid = 1'b1;
      push(K_RD, 1'b0, 32'h0000_1230, '0);
      push(K_UPD, 1'b0, '0, D1);
      tick();
      a_read_valid = 1'b0;
      samp();
      check("t1_c1_rden", mem_rden, 0);
      tick();
      samp();
      check("t1_c2_rden", mem_rden, 1);
      check("t1_c2_addr", mem_addr, 32'h0000_1230);
      tick();
      samp();
      check("t1_c3_valid", a_update_valid, 0);
      tick();
      // New pulse in the same cycle the read slot clears.
      a_addr = 32'h0000_1240;
      a_read_valid = 1'b1;
      push(K_RD, 1'b0, 32'h0000_1240, '0);
      push(K_UPD, 1'b0, '0, D2);
      samp();
      check("t1_c4_valid", a_update_valid, 1);
      check("t1_c4_line", a_update_line, D1);
      tick();
      a_read_valid = 1'b0;
      wait_drain("t1");
      check("t1_no_overflow", overflow_err, 0);

      // Contended reads.
      a_addr = 32'h0000_2000; a_read_valid = 1'b1;
      b_addr = 32'h0000_3000; b_read_valid = 1'b1;
      push(K_RD, 1'b0, 32'h0000_2000, '0);
      push(K_UPD, 1'b0, '0, D3);
      push(K_RD, 1'b0, 32'h0000_3000, '0);
      push(K_UPD, 1'b1, '0, D4);
      tick();
      a_read_valid = 1'b0; b_read_valid = 1'b0;
      wait_drain("t2a");

      a_read_valid = 1'b1; b_read_valid = 1'b1;
`ifdef L2ARB_ROUND_ROBIN_EN
      push(K_RD, 1'b0, 32'h0000_3000, '0);
      push(K_UPD, 1'b1, '0, D4);
      push(K_RD, 1'b0, 32'h0000_2000, '0);
      push(K_UPD, 1'b0, '0, D3);
`else
      push(K_RD, 1'b0, 32'h0000_2000, '0);
      push(K_UPD, 1'b0, '0, D3);
      push(K_RD, 1'b0, 32'h0000_3000, '0);
      push(K_UPD, 1'b1, '0, D4);
`endif
      tick();
      a_read_valid = 1'b0; b_read_valid = 1'b0;
      wait_drain("t2b");

      // B evicts the line A wants; write must land first, under a stalled port.
      mem_ready = 1'b0;
      a_addr = 32'h0000_4000; a_read_valid = 1'b1;
      b_addr = 32'h0000_4000; b_evict_wren = 1'b1; b_evict_line = D5;
      push(K_WR, 1'b0, 32'h0000_4000, D5);
      push(K_RD, 1'b0, 32'h0000_4000, '0);
      push(K_UPD, 1'b0, '0, D5);
      tick();
      a_read_valid = 1'b0; b_evict_wren = 1'b0;
      repeat (2) tick();
      samp();
      check("t3_wren_held", {mem_wren, mem_rden}, 2'b10);
      tick();
      mem_ready = 1'b1;
      wait_drain("t3");

      // Fill held back while b_irq is high.
      b_irq = 1'b1;
      b_addr = 32'h0000_5000; b_read_valid = 1'b1;
      push(K_RD, 1'b0, 32'h0000_5000, '0);
      push(K_UPD, 1'b1, '0, D6);
      tick();
      b_read_valid = 1'b0;
      repeat (3) tick();
      for (int i = 0; i < 5; i++) begin
         samp();
         check("t4_held_by_irq", b_update_valid, 0);
         tick();
      end
      b_irq = 1'b0;
      samp();
      check("t4_pulse_after_irq", b_update_valid, 1);
      tick();
      samp();
      check("t4_single_pulse", b_update_valid, 0);
      wait_drain("t4");

      // Second pulse into an occupied read slot.
      check("t5_ovf_before", overflow_err, 0);
      a_addr = 32'h0000_6000; a_read_valid = 1'b1;
      push(K_RD, 1'b0, 32'h0000_6000, '0);
      push(K_UPD, 1'b0, '0, D7);
      tick();
      a_addr = 32'h0000_7000;
      tick();
      a_read_valid = 1'b0;
      samp();
      check("t5_ovf_set", overflow_err, 1);
      wait_drain("t5");
      check("t5_ovf_sticky", overflow_err, 1);

      // Reset while waiting for read data; the late data must be ignored.
      hold_rd = 1'b1;
      a_addr = 32'h0000_1230; a_read_valid = 1'b1;
      push(K_RD, 1'b0, 32'h0000_1230, '0);
      tick();
      a_read_valid = 1'b0;
      tick();
      samp();
      check("t6_rden", mem_rden, 1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      samp();
      check("t6_reset_outputs", outs_nonzero(), 0);
      hold_rd = 1'b0;
      repeat (8) tick();
      samp();
      check("t6_after_late_data", outs_nonzero(), 0);
      tick();
      a_read_valid = 1'b1;
      push(K_RD, 1'b0, 32'h0000_1230, '0);
      push(K_UPD, 1'b0, '0, D1);
      tick();
      a_read_valid = 1'b0;
      wait_drain("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
